// File: rtl/vga_scanout_pkg.sv
// rtl/vga_scanout_pkg.sv - timing defaults and IRGB channel helper for vga_scanout
`include "vga_params.vh"

package vga_scanout_pkg;

  localparam int VGA_CLK_DIV = `VGA_CLK_DIV;
  localparam int VGA_H_VIS   = `VGA_H_VIS;
  localparam int VGA_H_FP    = `VGA_H_FP;
  localparam int VGA_H_SYNC  = `VGA_H_SYNC;
  localparam int VGA_H_BP    = `VGA_H_BP;
  localparam int VGA_V_VIS   = `VGA_V_VIS;
  localparam int VGA_V_FP    = `VGA_V_FP;
  localparam int VGA_V_SYNC  = `VGA_V_SYNC;
  localparam int VGA_V_BP    = `VGA_V_BP;
  localparam int VGA_ADR_W   = `VGA_ADR_W;

  // One IRGB colour channel: the intensity bit lifts both the lit and unlit levels.
  function automatic logic [3:0] chan_level(input logic on, input logic bright);
    if (on) begin
      return bright ? 4'hF : 4'hA;
    end
    return bright ? 4'h5 : 4'h0;
  endfunction

endpackage

// File: rtl/vga_palette.sv
// rtl/vga_palette.sv - combinational 4-bit IRGB index to 12-bit RGB table
module vga_palette
  import vga_scanout_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [11:0] rgb_o
);

  always_comb begin
    rgb_o = {chan_level(idx_i[2], idx_i[3]),
             chan_level(idx_i[1], idx_i[3]),
             chan_level(idx_i[0], idx_i[3])};
  end

endmodule

// File: rtl/vga_params.vh
// rtl/vga_params.vh - default 640x480@60 timing constants for vga_scanout
`ifndef VGA_PARAMS_VH
`define VGA_PARAMS_VH

`define VGA_CLK_DIV        2
`define VGA_H_VIS          640
`define VGA_H_FP           16
`define VGA_H_SYNC         96
`define VGA_H_BP           48
`define VGA_V_VIS          480
`define VGA_V_FP           10
`define VGA_V_SYNC         2
`define VGA_V_BP           33
`define VGA_ADR_W          19

`define VGA_H_TOT          (`VGA_H_VIS + `VGA_H_FP + `VGA_H_SYNC + `VGA_H_BP)
`define VGA_V_TOT          (`VGA_V_VIS + `VGA_V_FP + `VGA_V_SYNC + `VGA_V_BP)
`define VGA_H_SYNC_START   (`VGA_H_VIS + `VGA_H_FP)
`define VGA_H_SYNC_END     (`VGA_H_SYNC_START + `VGA_H_SYNC - 1)
`define VGA_V_SYNC_START   (`VGA_V_VIS + `VGA_V_FP)
`define VGA_V_SYNC_END     (`VGA_V_SYNC_START + `VGA_V_SYNC - 1)
`define VGA_FB_SIZE        (`VGA_H_VIS * `VGA_V_VIS)

`endif

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator and framebuffer scanout with IRGB palette
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP,
  parameter int ADR_W   = VGA_ADR_W
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             frame_ready_i,
  output logic [ADR_W-1:0] adr_o,
  output logic             re_o,
  input  logic [3:0]       dat_i,
  output logic [3:0]       vga_r_o,
  output logic [3:0]       vga_g_o,
  output logic [3:0]       vga_b_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             frame_start_o
);

  localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_SIZE = H_VIS * V_VIS;
  localparam int DW      = $clog2(CLK_DIV);
  localparam int HW      = $clog2(H_TOT);
  localparam int VW      = $clog2(V_TOT);

  localparam logic [DW-1:0]    DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0]    H_VIS_L  = HW'(H_VIS);
  localparam logic [HW-1:0]    H_SYNC_S = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0]    H_SYNC_E = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0]    V_VIS_L  = VW'(V_VIS);
  localparam logic [VW-1:0]    V_SYNC_S = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0]    V_SYNC_E = VW'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [ADR_W-1:0] LIN_LAST = ADR_W'(FB_SIZE - 1);

  logic [DW-1:0]    div_q, div_d;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic [ADR_W-1:0] lin_q, lin_d;
  logic             en_q, en_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             re_q, re_d;
  logic             vis_a_q, vis_a_d;
  logic             hs_a_q, hs_a_d;
  logic             vs_a_q, vs_a_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             fs_q, fs_d;

  logic             pix_en, origin, vis, h_sync_act, v_sync_act, en_cur;
  logic [ADR_W-1:0] lin_cur;
  logic [11:0]      pal_rgb;

  vga_palette u_palette (
    .idx_i (dat_i),
    .rgb_o (pal_rgb)
  );

  always_comb begin
    pix_en     = (div_q == DIV_LAST);
    origin     = (h_q == '0) && (v_q == '0);
    vis        = (h_q < H_VIS_L) && (v_q < V_VIS_L);
    h_sync_act = (h_q >= H_SYNC_S) && (h_q <= H_SYNC_E);
    v_sync_act = (v_q >= V_SYNC_S) && (v_q <= V_SYNC_E);
    // Arming takes effect on the origin tick itself so pixel (0,0) is already read.
    en_cur     = en_q | (origin & frame_ready_i);
    lin_cur    = origin ? '0 : lin_q;
  end

  always_comb begin
    div_d   = pix_en ? '0 : div_q + 1'b1;
    h_d     = h_q;
    v_d     = v_q;
    lin_d   = lin_q;
    en_d    = en_q;
    adr_d   = adr_q;
    re_d    = 1'b0;
    vis_a_d = vis_a_q;
    hs_a_d  = hs_a_q;
    vs_a_d  = vs_a_q;
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    fs_d    = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      if (vis) begin
        lin_d = (lin_cur == LIN_LAST) ? '0 : lin_cur + 1'b1;
      end else begin
        lin_d = lin_cur;
      end
      en_d    = en_cur;
      fs_d    = origin;
      adr_d   = lin_cur;
      re_d    = vis & en_cur;
      vis_a_d = vis & en_cur;
      hs_a_d  = ~h_sync_act;
      vs_a_d  = ~v_sync_act;
      // dat_i answers the stage-A read one clk later, well before this tick.
      rgb_d   = vis_a_q ? pal_rgb : 12'h000;
      hsync_d = hs_a_q;
      vsync_d = vs_a_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      lin_q   <= '0;
      en_q    <= 1'b0;
      adr_q   <= '0;
      re_q    <= 1'b0;
      vis_a_q <= 1'b0;
      hs_a_q  <= 1'b1;
      vs_a_q  <= 1'b1;
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      lin_q   <= lin_d;
      en_q    <= en_d;
      adr_q   <= adr_d;
      re_q    <= re_d;
      vis_a_q <= vis_a_d;
      hs_a_q  <= hs_a_d;
      vs_a_q  <= vs_a_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign adr_o         = adr_q;
  assign re_o          = re_q;
  assign vga_r_o       = rgb_q[11:8];
  assign vga_g_o       = rgb_q[7:4];
  assign vga_b_o       = rgb_q[3:0];
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout on a reduced raster
module tb_vga_scanout;

  localparam int CLK_DIV   = 2;
  localparam int H_VIS     = 16;
  localparam int H_FP      = 4;
  localparam int H_SYNC    = 6;
  localparam int H_BP      = 6;
  localparam int V_VIS     = 5;
  localparam int V_FP      = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 3;
  localparam int ADR_W     = 19;
  localparam int H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int LINE_CLK  = H_TOT * CLK_DIV;
  localparam int FRAME_CLK = LINE_CLK * V_TOT;
  localparam int FB_SIZE   = H_VIS * V_VIS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_ready = 1'b0;
  logic [ADR_W-1:0] adr;
  logic             re;
  logic [3:0]       dat = 4'h0;
  logic [3:0]       vr, vg, vb;
  logic             hsync, vsync, fs;
  logic [11:0]      rgb;

  assign rgb = {vr, vg, vb};

  vga_scanout #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .ADR_W(ADR_W)
  ) dut (
    .clk_i         (clk),
    .rst           (rst),
    .frame_ready_i (frame_ready),
    .adr_o         (adr),
    .re_o          (re),
    .dat_i         (dat),
    .vga_r_o       (vr),
    .vga_g_o       (vg),
    .vga_b_o       (vb),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .frame_start_o (fs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer model: ram[a] = a[3:0], registered one clk after the read strobe.
  always @(posedge clk) if (re) dat <= adr[3:0];

  typedef struct {
    int          due;
    logic [11:0] rgb;
  } pix_t;

  logic [11:0] pal_tab [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA,
                                12'hA00, 12'hA0A, 12'hAA0, 12'hAAA,
                                12'h555, 12'h55F, 12'h5F5, 12'h5FF,
                                12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  pix_t sb_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   mon_on     = 1'b0;
  int   exp_adr    = 0;
  int   cur_until  = 0;
  int   blank_err  = 0;
  int   reads      = 0;
  bit   prev_re    = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (re) begin
        vectors++;
        if (adr !== ADR_W'(exp_adr)) begin
          miscompares++;
          $display("FAIL sb_adr: cyc %0d adr_o=%0d expected %0d", cyc, adr, exp_adr);
        end
        vectors++;
        if (prev_re) begin
          miscompares++;
          $display("FAIL re_pulse: cyc %0d re_o high on two consecutive clks, expected single pulse", cyc);
        end
        sb_q.push_back('{due: cyc + CLK_DIV, rgb: pal_tab[exp_adr % 16]});
        exp_adr = (exp_adr + 1) % FB_SIZE;
        reads++;
      end
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        vectors++;
        if (rgb !== sb_q[0].rgb) begin
          miscompares++;
          $display("FAIL sb_rgb: cyc %0d rgb=%h expected %h", cyc, rgb, sb_q[0].rgb);
        end
        cur_until = cyc + CLK_DIV;
        void'(sb_q.pop_front());
      end else if (cyc >= cur_until && rgb !== 12'h000) begin
        blank_err++;
      end
    end
    prev_re = re;
  end

  task automatic sb_flush();
    sb_q.delete();
    exp_adr   = 0;
    cur_until = 0;
  endtask

  task automatic do_reset(input bit fr, input int n);
    @(negedge clk);
    mon_on      = 1'b0;
    frame_ready = fr;
    rst         = 1'b1;
    repeat (n) @(negedge clk);
    sb_flush();
    rst    = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_ready = 1'b0; mon_on = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (hsync !== 1'b1) begin miscompares++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    vectors++; if (vsync !== 1'b1) begin miscompares++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
    vectors++; if (re !== 1'b0) begin miscompares++; $display("FAIL reset_re: got %b expected 0", re); end
    vectors++; if (rgb !== 12'h000) begin miscompares++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    vectors++; if (adr !== '0) begin miscompares++; $display("FAIL reset_adr: got %0d expected 0", adr); end
    vectors++; if (fs !== 1'b0) begin miscompares++; $display("FAIL reset_fs: got %b expected 0", fs); end
    sb_flush();
    rst = 1'b0; mon_on = 1'b1;
    repeat (CLK_DIV - 1) @(negedge clk);
    vectors++; if (fs !== 1'b0) begin miscompares++; $display("FAIL first_tick_early: fs=%b expected 0", fs); end
    @(negedge clk);
    vectors++; if (fs !== 1'b1) begin miscompares++; $display("FAIL first_tick: fs=%b expected 1 at %0d clks after reset", fs, CLK_DIV); end
  endtask

  task automatic test_timing();
    int hf[$]; int hr[$]; int vf[$]; int vr_t[$]; int fsc[$];
    logic ph, pv, pf;
    int r0, b0, bad, fs_wide, hs_low, vs_low, lines;
    r0 = reads; b0 = blank_err; bad = 0; fs_wide = 0; hs_low = -1; vs_low = -1; lines = 0;
    ph = hsync; pv = vsync; pf = fs;
    for (int i = 0; i < 2 * FRAME_CLK + LINE_CLK; i++) begin
      @(negedge clk);
      if (ph && !hsync) hf.push_back(cyc);
      if (!ph && hsync) hr.push_back(cyc);
      if (pv && !vsync) vf.push_back(cyc);
      if (!pv && vsync) vr_t.push_back(cyc);
      if (fs && !pf) fsc.push_back(cyc);
      if (fs && pf) fs_wide++;
      ph = hsync; pv = vsync; pf = fs;
    end
    vectors++;
    if (hf.size() < 2 || vf.size() < 2 || fsc.size() < 2) begin
      miscompares++;
      $display("FAIL timing_edges: hs falls %0d vs falls %0d fs pulses %0d, expected >=2 each", hf.size(), vf.size(), fsc.size());
    end else begin
      for (int k = 1; k < hf.size(); k++) if (hf[k] - hf[k-1] != LINE_CLK) bad++;
      foreach (hr[k]) if (hs_low < 0 && hr[k] > hf[0]) hs_low = hr[k] - hf[0];
      foreach (vr_t[k]) if (vs_low < 0 && vr_t[k] > vf[0]) vs_low = vr_t[k] - vf[0];
      foreach (hf[k]) if (hf[k] >= vf[0] && hf[k] < vf[1]) lines++;
      vectors++; if (hf[1] - hf[0] != LINE_CLK) begin miscompares++; $display("FAIL hs_period: got %0d expected %0d", hf[1] - hf[0], LINE_CLK); end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL hs_period_all: %0d bad periods expected 0", bad); end
      vectors++; if (hs_low != H_SYNC * CLK_DIV) begin miscompares++; $display("FAIL hs_low: got %0d expected %0d", hs_low, H_SYNC * CLK_DIV); end
      vectors++; if (vf[1] - vf[0] != FRAME_CLK) begin miscompares++; $display("FAIL vs_period: got %0d expected %0d", vf[1] - vf[0], FRAME_CLK); end
      vectors++; if (vs_low != V_SYNC * LINE_CLK) begin miscompares++; $display("FAIL vs_low: got %0d expected %0d", vs_low, V_SYNC * LINE_CLK); end
      vectors++; if (lines != V_TOT) begin miscompares++; $display("FAIL lines_per_frame: got %0d expected %0d", lines, V_TOT); end
      vectors++; if (fsc[1] - fsc[0] != FRAME_CLK) begin miscompares++; $display("FAIL fs_period: got %0d expected %0d", fsc[1] - fsc[0], FRAME_CLK); end
    end
    vectors++; if (fs_wide != 0) begin miscompares++; $display("FAIL fs_width: %0d extra high clks expected 0", fs_wide); end
    vectors++; if (reads != r0) begin miscompares++; $display("FAIL idle_reads: got %0d reads expected 0", reads - r0); end
    vectors++; if (blank_err != b0) begin miscompares++; $display("FAIL idle_rgb: %0d nonzero clks expected 0", blank_err - b0); end
  endtask

  task automatic test_addressing();
    int ra[$]; int rc[$];
    int fs_cnt, b0;
    do_reset(1'b1, 3);
    fs_cnt = 0; b0 = blank_err;
    for (int i = 0; i < 2 * FRAME_CLK + LINE_CLK && fs_cnt < 2; i++) begin
      @(negedge clk);
      if (fs) fs_cnt++;
      if (re && fs_cnt == 1) begin ra.push_back(int'(adr)); rc.push_back(cyc); end
    end
    vectors++; if (fs_cnt != 2) begin miscompares++; $display("FAIL addr_timeout: saw %0d frame starts expected 2", fs_cnt); end
    vectors++; if (ra.size() != FB_SIZE) begin miscompares++; $display("FAIL reads_per_frame: got %0d expected %0d", ra.size(), FB_SIZE); end
    if (ra.size() > H_VIS) begin
      vectors++; if (ra[0] != 0) begin miscompares++; $display("FAIL first_adr: got %0d expected 0", ra[0]); end
      vectors++; if (ra[H_VIS] != H_VIS) begin miscompares++; $display("FAIL line1_adr: got %0d expected %0d", ra[H_VIS], H_VIS); end
      vectors++;
      if (rc[H_VIS] - rc[H_VIS-1] != (H_TOT - H_VIS + 1) * CLK_DIV) begin
        miscompares++;
        $display("FAIL line_gap: got %0d clks expected %0d", rc[H_VIS] - rc[H_VIS-1], (H_TOT - H_VIS + 1) * CLK_DIV);
      end
      vectors++; if (rc[1] - rc[0] != CLK_DIV) begin miscompares++; $display("FAIL pixel_spacing: got %0d expected %0d", rc[1] - rc[0], CLK_DIV); end
      vectors++; if (ra[ra.size()-1] != FB_SIZE - 1) begin miscompares++; $display("FAIL last_adr: got %0d expected %0d", ra[ra.size()-1], FB_SIZE - 1); end
    end
    vectors++; if (blank_err != b0) begin miscompares++; $display("FAIL addr_blank: %0d nonzero blank clks expected 0", blank_err - b0); end
  endtask

  task automatic test_datapath();
    int t7, t12, t15, t16, b0;
    bit got_fs, d7, d12, d15, d16;
    t7 = -1; t12 = -1; t15 = -1; t16 = -1; b0 = blank_err;
    got_fs = 0; d7 = 0; d12 = 0; d15 = 0; d16 = 0;
    for (int i = 0; i < 2 * FRAME_CLK && !(d7 && d12 && d15 && d16); i++) begin
      @(negedge clk);
      if (fs) got_fs = 1;
      if (got_fs && re) begin
        if (adr == 7)  t7  = cyc + CLK_DIV;
        if (adr == 12) t12 = cyc + CLK_DIV;
        if (adr == 15) t15 = cyc + CLK_DIV;
        if (adr == 16) t16 = cyc + CLK_DIV;
      end
      if (cyc == t7)  begin d7 = 1;  vectors++; if (rgb !== 12'hAAA) begin miscompares++; $display("FAIL pix7: rgb=%h expected AAA", rgb); end end
      if (cyc == t12) begin d12 = 1; vectors++; if (rgb !== 12'hF55) begin miscompares++; $display("FAIL pix12: rgb=%h expected F55", rgb); end end
      if (cyc == t15) begin d15 = 1; vectors++; if (rgb !== 12'hFFF) begin miscompares++; $display("FAIL pix15: rgb=%h expected FFF", rgb); end end
      if (cyc == t16) begin d16 = 1; vectors++; if (rgb !== 12'h000) begin miscompares++; $display("FAIL pix16: rgb=%h expected 000", rgb); end end
    end
    vectors++; if (!(d7 && d12 && d15 && d16)) begin miscompares++; $display("FAIL datapath_timeout: seen %b%b%b%b expected 1111", d7, d12, d15, d16); end
    vectors++; if (blank_err != b0) begin miscompares++; $display("FAIL porch_rgb: %0d nonzero blank clks expected 0", blank_err - b0); end
  endtask

  task automatic test_gating();
    int early_re, early_rgb, frame_reads, b0;
    bit seen;
    do_reset(1'b0, 3);
    repeat (100) @(negedge clk);
    frame_ready = 1'b1;
    early_re = 0; early_rgb = 0; seen = 0; b0 = blank_err;
    for (int i = 0; i < 2 * FRAME_CLK && !seen; i++) begin
      @(negedge clk);
      if (fs) seen = 1;
      else begin
        if (re) early_re++;
        if (rgb !== 12'h000) early_rgb++;
      end
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL gate_timeout: no frame_start within %0d clks", 2 * FRAME_CLK); end
    vectors++; if (early_re != 0) begin miscompares++; $display("FAIL gate_reads: got %0d reads before frame start expected 0", early_re); end
    vectors++; if (early_rgb != 0) begin miscompares++; $display("FAIL gate_rgb: got %0d nonzero clks before frame start expected 0", early_rgb); end
    vectors++; if (re !== 1'b1 || adr !== '0) begin miscompares++; $display("FAIL arm_read: re=%b adr=%0d expected re=1 adr=0", re, adr); end
    frame_reads = 1; seen = 0;
    for (int i = 0; i < 2 * FRAME_CLK && !seen; i++) begin
      @(negedge clk);
      if (i == FRAME_CLK / 3) frame_ready = 1'b0;
      if (fs) seen = 1;
      else if (re) frame_reads++;
    end
    vectors++; if (frame_reads != FB_SIZE) begin miscompares++; $display("FAIL drop_ready_reads: got %0d expected %0d", frame_reads, FB_SIZE); end
    vectors++; if (re !== 1'b1) begin miscompares++; $display("FAIL drop_ready_next: re=%b expected 1 at next frame start", re); end
    vectors++; if (blank_err != b0) begin miscompares++; $display("FAIL gate_blank: %0d nonzero blank clks expected 0", blank_err - b0); end
  endtask

  task automatic test_reset_mid();
    bit hit, fs_seen, done;
    int rel;
    frame_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 2 * FRAME_CLK && !hit; i++) begin
      @(negedge clk);
      if (re && adr == ADR_W'(2 * H_VIS + 7)) hit = 1;
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL mid_timeout: adr %0d never read", 2 * H_VIS + 7); end
    mon_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (hsync !== 1'b1 || vsync !== 1'b1) begin miscompares++; $display("FAIL mid_syncs: hsync=%b vsync=%b expected 1 1", hsync, vsync); end
    vectors++; if (re !== 1'b0 || fs !== 1'b0) begin miscompares++; $display("FAIL mid_strobes: re=%b fs=%b expected 0 0", re, fs); end
    vectors++; if (rgb !== 12'h000 || adr !== '0) begin miscompares++; $display("FAIL mid_data: rgb=%h adr=%0d expected 000 0", rgb, adr); end
    sb_flush();
    rst = 1'b0; mon_on = 1'b1;
    rel = cyc; fs_seen = 0; done = 0;
    for (int i = 0; i < 2 * FRAME_CLK && !done; i++) begin
      @(negedge clk);
      if (fs) fs_seen = 1;
      if (re) begin
        done = 1;
        vectors++; if (!fs_seen) begin miscompares++; $display("FAIL mid_read_early: read at cyc %0d before frame start", cyc); end
        vectors++; if (adr !== '0) begin miscompares++; $display("FAIL mid_first_adr: got %0d expected 0", adr); end
        vectors++; if (cyc - rel != CLK_DIV) begin miscompares++; $display("FAIL mid_restart: first read %0d clks after release expected %0d", cyc - rel, CLK_DIV); end
      end
    end
    vectors++; if (!done) begin miscompares++; $display("FAIL mid_no_read: no read after reset release"); end
    repeat (LINE_CLK) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_timing();
    test_addressing();
    test_datapath();
    test_gating();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
